qp_mem_arbiter: RTL

QP_MEM_ARBITER -- requirements
Module: qp_mem_arbiter

---
 rtl/qp_mem_arbiter.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/qp_mem_arbiter.sv
// -----------------------------------------------------------------------------
// qp_mem_arbiter
//
// Shares a single-port query-patch SRAM between the patch-matching engine and
// a Wishbone debug port. The engine owns the SRAM by default. When the
// Wishbone side raises wbs_debug, ownership moves over once no engine read is
// still waiting for its data. Ownership returns to the engine once wbs_debug
// drops while the Wishbone side is idle.
//
// Engine reads return in order through a 2-entry response FIFO. A read is
// only accepted when it is guaranteed a FIFO slot.
//
// Ports
//   wb_clk_i, wb_rst_ni        clock, synchronous active-low reset
//   wbs_debug                  Wishbone side requests SRAM ownership
//   wbs_qp_mem_*               Wishbone-side SRAM port (csb/web active-low)
//   eng_req_*                  engine request channel (valid/ready)
//   eng_rsp_*                  engine read-response channel (valid/ready)
//   mem_*                      SRAM port 0 (csb/web active-low)
//   wbs_drop                   sticky: a Wishbone access arrived without
//                              ownership and was discarded
//
// State table
//   ENG   | engine owns the SRAM
//   DRAIN | handover requested, waiting for the last engine read to land
//   WBS   | Wishbone side owns the SRAM
// -----------------------------------------------------------------------------
module qp_mem_arbiter #(
    parameter int DATA_WIDTH = 11,
    parameter int PATCH_SIZE = 5,
    parameter int NUM_QUERYS = 408,
    parameter int ADDRW      = $clog2(NUM_QUERYS)
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rst_ni,

    input  logic                             wbs_debug,
    input  logic                             wbs_qp_mem_csb0,
    input  logic                             wbs_qp_mem_web0,
    input  logic [ADDRW-1:0]                 wbs_qp_mem_addr0,
    input  logic [PATCH_SIZE*DATA_WIDTH-1:0] wbs_qp_mem_wpatch0,
    output logic [PATCH_SIZE*DATA_WIDTH-1:0] wbs_qp_mem_rpatch0,

    input  logic                             eng_req_valid,
    input  logic                             eng_req_we,
    input  logic [ADDRW-1:0]                 eng_req_addr,
    input  logic [PATCH_SIZE*DATA_WIDTH-1:0] eng_req_wpatch,
    output logic                             eng_req_ready,

    output logic                             eng_rsp_valid,
    input  logic                             eng_rsp_ready,
    output logic [PATCH_SIZE*DATA_WIDTH-1:0] eng_rsp_rpatch,

    output logic                             mem_csb0,
    output logic                             mem_web0,
    output logic [ADDRW-1:0]                 mem_addr0,
    output logic [PATCH_SIZE*DATA_WIDTH-1:0] mem_wpatch0,
    input  logic [PATCH_SIZE*DATA_WIDTH-1:0] mem_rpatch0,

    output logic                             wbs_drop
);

    localparam int PW = PATCH_SIZE * DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_ENG   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_WBS   = 2'd2
    } state_e;

    state_e          state_q, state_d;

    // One-cycle SRAM read latency means at most one engine read is ever
    // between acceptance and capture.
    logic            rd_infl_q, rd_infl_d;

    logic [1:0]      cnt_q, cnt_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   fifo_q [2];

    logic            drop_q, drop_d;

    logic            credit_ok;
    logic            accept;
    logic            rd_accept;
    logic            push;
    logic            pop;

    // Credits count FIFO occupancy plus the read still in flight. A pop in
    // the same cycle is deliberately not credited, which keeps the ready path
    // independent of eng_rsp_ready.
    assign credit_ok = (({1'b0, cnt_q} + {2'b00, rd_infl_q}) < 3'd2);

    assign accept    = eng_req_valid && eng_req_ready;
    assign rd_accept = accept && !eng_req_we;
    assign push      = rd_infl_q;
    assign pop       = (cnt_q != 2'd0) && eng_rsp_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q <= ST_ENG;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ENG: begin
                if (wbs_debug) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A read accepted on the way into DRAIN lands in the FIFO at
                // the end of this cycle, so nothing is left in flight after
                // this edge and the SRAM is free for the Wishbone side.
                if (!rd_infl_d) begin
                    state_d = ST_WBS;
                end
            end
            ST_WBS: begin
                // Only hand back while the Wishbone side is idle, so an
                // access in progress is never cut off.
                if (!wbs_debug && wbs_qp_mem_csb0) begin
                    state_d = ST_ENG;
                end
            end
            default: begin
                state_d = ST_ENG;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (SRAM mux and engine ready)
    // ------------------------------------------------------------------
    always_comb begin
        eng_req_ready = 1'b0;
        mem_csb0      = 1'b1;
        mem_web0      = 1'b1;
        mem_addr0     = '0;
        mem_wpatch0   = '0;

        if (wb_rst_ni) begin
            unique case (state_q)
                ST_ENG: begin
                    eng_req_ready = eng_req_we || credit_ok;
                    if (eng_req_valid && eng_req_ready) begin
                        mem_csb0    = 1'b0;
                        mem_web0    = !eng_req_we;
                        mem_addr0   = eng_req_addr;
                        mem_wpatch0 = eng_req_wpatch;
                    end
                end
                ST_WBS: begin
                    mem_csb0    = wbs_qp_mem_csb0;
                    mem_web0    = wbs_qp_mem_web0;
                    mem_addr0   = wbs_qp_mem_addr0;
                    mem_wpatch0 = wbs_qp_mem_wpatch0;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO and drop flag: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        rd_infl_d = rd_accept;
        rd_ptr_d  = rd_ptr_q ^ pop;
        wr_ptr_d  = wr_ptr_q ^ push;

        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        // A Wishbone select without ownership never reaches the SRAM.
        drop_d = drop_q;
        if ((state_q != ST_WBS) && !wbs_qp_mem_csb0) begin
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            rd_infl_q <= 1'b0;
            cnt_q     <= 2'd0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            rd_infl_q <= rd_infl_d;
            cnt_q     <= cnt_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            drop_q    <= drop_d;
        end
    end

    // Storage needs no reset; the count alone decides what is valid.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= mem_rpatch0;
        end
    end

    assign eng_rsp_valid      = (cnt_q != 2'd0);
    assign eng_rsp_rpatch     = fifo_q[rd_ptr_q];
    assign wbs_qp_mem_rpatch0 = mem_rpatch0;
    assign wbs_drop           = drop_q;

endmodule
